// File: rtl/dnn_pkg.sv
// Shared configuration, state encoding and row-count helpers for the
// DNN weight streamer.
package dnn_pkg;

  localparam int M_W_BitSize  = 16;
  localparam int MaxNumNerves = 6;
  localparam int NumLayers    = 4;
  localparam int ImageSize    = 16;
  localparam int AddrWidth    = 10;
  // Index 0 is the leftmost entry; LNN[NumLayers-1-k] is the nerve count of layer k.
  localparam int LNN [0:NumLayers-1] = '{2, 3, 5, 6};

  localparam int ROW_BUS_W = MaxNumNerves * M_W_BitSize;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} wstream_state_t;

  // Rows consumed by layer k: the flattened image for layer 0, otherwise one
  // row per nerve of the preceding layer.
  function automatic int layer_rows(input int k);
    if (k == 0) return ImageSize;
    return LNN[NumLayers - k];
  endfunction

  function automatic int layer_nerves(input int k);
    return LNN[NumLayers - 1 - k];
  endfunction

  function automatic int total_rows();
    int sum;
    sum = 0;
    for (int k = 0; k < NumLayers; k++) sum += layer_rows(k);
    return sum;
  endfunction

  function automatic int max_rows();
    int mx;
    mx = 0;
    for (int k = 0; k < NumLayers; k++)
      if (layer_rows(k) > mx) mx = layer_rows(k);
    return mx;
  endfunction

  localparam int TOTAL_ROWS = total_rows();
  localparam int LAYER_W    = $clog2(NumLayers);
  localparam int ROW_W      = $clog2(max_rows());
  localparam int CNT_W      = $clog2(TOTAL_ROWS + 1);

endpackage

// File: rtl/dnn_wstream_row_counter.sv
// Layer / row-in-layer bookkeeping for the streamed burst. Advances once per
// output row and wraps back to layer 0 after the final row of the last layer.
// With DNN_WSTREAM_LANE_MASK_EN, also exports the layer of the row shown next.
module dnn_wstream_row_counter
  import dnn_pkg::*;
(
  input  logic               clk,
  input  logic               res,
  input  logic               adv_i,
`ifdef DNN_WSTREAM_LANE_MASK_EN
  output logic [LAYER_W-1:0] layer_next_o,
`endif
  output logic [LAYER_W-1:0] layer_o,
  output logic               first_o,
  output logic               last_row_o
);

  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               layer_end;

  // Next-count logic: wrap row at the layer boundary, wrap layer after the last row.
  always_comb begin
    layer_d    = layer_q;
    row_d      = row_q;
    layer_end  = (row_q == ROW_W'(layer_rows(int'(layer_q)) - 1));
    last_row_o = layer_end && (layer_q == LAYER_W'(NumLayers - 1));
    if (adv_i) begin
      if (layer_end) begin
        row_d   = '0;
        layer_d = last_row_o ? '0 : layer_q + LAYER_W'(1);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (res) begin
      layer_q <= '0;
      row_q   <= '0;
    end else begin
      layer_q <= layer_d;
      row_q   <= row_d;
    end
  end

  assign layer_o = layer_q;
  assign first_o = (row_q == '0);
`ifdef DNN_WSTREAM_LANE_MASK_EN
  assign layer_next_o = layer_d;
`endif

endmodule

// File: rtl/dnn_weight_streamer.sv
// Weight-load transmitter: on start, reads TOTAL_ROWS consecutive rows from a
// 1-cycle-latency memory and emits them as one gap-free burst, with a consumer
// reset pulse the cycle before row 0 and a done pulse after the last row.
// Optional DNN_WSTREAM_LANE_MASK_EN zeroes lanes unused by the row's layer.
//
// state  | meaning
// IDLE   | waiting for start
// PRIME  | first read issued at base address
// STREAM | remaining reads issued, rows emitted
// DONE   | one-cycle completion pulse
module dnn_weight_streamer
  import dnn_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    res,
  input  logic                                    start,
  input  logic [AddrWidth-1:0]                    base_addr,
  output logic                                    mem_rd_en,
  output logic [AddrWidth-1:0]                    mem_addr,
  input  logic [ROW_BUS_W-1:0]                    mem_rd_data,
  output logic                                    out_res_n,
  output logic                                    out_valid,
  output logic [MaxNumNerves-1:0][M_W_BitSize-1:0] out_weights,
  output logic [LAYER_W-1:0]                      out_layer,
  output logic                                    out_layer_first,
  output logic                                    busy,
  output logic                                    done
);

  for (genvar k = 0; k < NumLayers; k++) begin : g_cfg_chk
    if (layer_rows(k) == 0) begin : g_zero_rows
      $error("dnn_weight_streamer: layer with zero rows");
    end
    if (LNN[k] > MaxNumNerves) begin : g_too_many_nerves
      $error("dnn_weight_streamer: LNN entry exceeds MaxNumNerves");
    end
  end

  wstream_state_t state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q;   // memory data for a read is on mem_rd_data this cycle
  logic                 valid_q;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] weights_q, load_row;
  logic [LAYER_W-1:0]   layer;
  logic                 first, last_row;
`ifdef DNN_WSTREAM_LANE_MASK_EN
  logic [LAYER_W-1:0]   layer_next;
`endif

  dnn_wstream_row_counter u_row_cnt (
    .clk          (clk),
    .res          (res),
    .adv_i        (valid_q),
`ifdef DNN_WSTREAM_LANE_MASK_EN
    .layer_next_o (layer_next),
`endif
    .layer_o      (layer),
    .first_o      (first),
    .last_row_o   (last_row)
  );

  // Sequencing: issue TOTAL_ROWS reads, finish once the last row is on the bus.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    mem_rd_en = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          cnt_d   = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        mem_rd_en = 1'b1;
        addr_d    = addr_q + AddrWidth'(1);
        cnt_d     = CNT_W'(1);
        state_d   = STREAM;
      end
      STREAM: begin
        if (cnt_q < CNT_W'(TOTAL_ROWS)) begin
          mem_rd_en = 1'b1;
          addr_d    = addr_q + AddrWidth'(1);
          cnt_d     = cnt_q + CNT_W'(1);
        end
        if (valid_q && last_row) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row about to be captured; the next row's layer decides which lanes survive.
  always_comb begin
    load_row = mem_rd_data;
`ifdef DNN_WSTREAM_LANE_MASK_EN
    for (int i = 0; i < MaxNumNerves; i++)
      if (i < MaxNumNerves - layer_nerves(int'(layer_next))) load_row[i] = '0;
`endif
  end

  // State, address, read pipeline and row register.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      weights_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pend_q  <= mem_rd_en;
      valid_q <= pend_q;
      if (pend_q) weights_q <= load_row;
    end
  end

  assign mem_addr        = mem_rd_en ? addr_q : '0;
  // First data beat is in flight but nothing shown yet: the cycle before row 0.
  assign out_res_n       = !(pend_q && !valid_q);
  assign out_valid       = valid_q;
  assign out_weights     = weights_q;
  assign out_layer       = valid_q ? layer : '0;
  assign out_layer_first = valid_q && first;
  assign busy            = (state_q != IDLE);

endmodule
